// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: issues data-memory requests, stalls upstream until the
// access completes, formats load data and drives the MEM/WB pipeline register.
module mem_stage_lsu (
    input  logic        clk,
    input  logic        arst,
    input  logic        memValid,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [2:0]  memFunct3,
    input  logic [31:0] memAddr,
    input  logic [31:0] memStoreData,
    input  logic [4:0]  rdAddr,
    input  logic        rdWriteEn,
    input  logic [1:0]  destinationSelect,
    input  logic [31:0] pc,
    output logic        stall,
    output logic        dmemReqValid,
    input  logic        dmemReqReady,
    output logic [31:0] dmemReqAddr,
    output logic        dmemReqWe,
    output logic [3:0]  dmemReqBe,
    output logic [31:0] dmemReqWdata,
    input  logic        dmemRspValid,
    input  logic [31:0] dmemRspData,
    output logic        wbValid,
    output logic [4:0]  wbRdAddr,
    output logic        wbRdWriteEn,
    output logic [1:0]  wbDestinationSelect,
    output logic [31:0] wbPc,
    output logic [31:0] wbRdWriteData,
    output logic        wbMisaligned,
    output logic        fsm_state
);

    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

    state_t      state;
    logic [1:0]  addr_q;
    logic        mem_op;
    logic        is_half;
    logic        is_word;
    logic        misaligned;
    logic        done;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_data;

    assign fsm_state  = state;
    assign mem_op     = memValid & (memRead | memWrite);
    assign is_half    = (memFunct3[1:0] == 2'b01);
    assign is_word    = (memFunct3[1:0] == 2'b10);
    assign misaligned = mem_op & ((is_half & memAddr[0]) | (is_word & (memAddr[1:0] != 2'b00)));

    // Request handshake: a request transfers on a cycle where dmemReqValid and
    // dmemReqReady are both high; until then valid and all payload fields hold steady.
    // The response is a one-cycle dmemRspValid pulse, only ever expected in WAIT.
    assign dmemReqValid = mem_op & ~misaligned & (state == IDLE) & ~arst;
    assign dmemReqAddr  = {memAddr[31:2], 2'b00};
    assign dmemReqWe    = memWrite;

    always_comb begin
        done = 1'b0;
        case (state)
            IDLE:    done = memWrite & dmemReqReady;
            WAIT:    done = dmemRspValid;
            default: done = 1'b0;
        endcase
    end

    // Held low during reset so an abandoned access frees the pipeline at once.
    assign stall = mem_op & ~misaligned & ~done & ~arst;

    always_comb begin
        dmemReqBe    = 4'b1111;
        dmemReqWdata = memStoreData;
        if (memWrite) begin
            case (memFunct3[1:0])
                2'b00: begin
                    dmemReqBe    = 4'b0001 << memAddr[1:0];
                    dmemReqWdata = {4{memStoreData[7:0]}};
                end
                2'b01: begin
                    dmemReqBe    = 4'b0011 << memAddr[1:0];
                    dmemReqWdata = {2{memStoreData[15:0]}};
                end
                default: begin
                    dmemReqBe    = 4'b1111;
                    dmemReqWdata = memStoreData;
                end
            endcase
        end
    end

    always_comb begin
        lane_byte = dmemRspData[7:0];
        case (addr_q)
            2'b00:   lane_byte = dmemRspData[7:0];
            2'b01:   lane_byte = dmemRspData[15:8];
            2'b10:   lane_byte = dmemRspData[23:16];
            default: lane_byte = dmemRspData[31:24];
        endcase
        lane_half = addr_q[1] ? dmemRspData[31:16] : dmemRspData[15:0];
        load_data = dmemRspData;
        case (memFunct3)
            3'b000:  load_data = {{24{lane_byte[7]}}, lane_byte};
            3'b100:  load_data = {24'h000000, lane_byte};
            3'b001:  load_data = {{16{lane_half[15]}}, lane_half};
            3'b101:  load_data = {16'h0000, lane_half};
            default: load_data = dmemRspData;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state  <= IDLE;
            addr_q <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (dmemReqValid & dmemReqReady & memRead) begin
                        state  <= WAIT;
                        addr_q <= memAddr[1:0];
                    end
                end
                WAIT: begin
                    if (dmemRspValid) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wbValid             <= 1'b0;
            wbRdAddr            <= 5'd0;
            wbRdWriteEn         <= 1'b0;
            wbDestinationSelect <= 2'd0;
            wbPc                <= 32'd0;
            wbRdWriteData       <= 32'd0;
            wbMisaligned        <= 1'b0;
        end else if (stall | ~memValid) begin
            wbValid     <= 1'b0;
            wbRdWriteEn <= 1'b0;
        end else begin
            wbValid             <= 1'b1;
            wbRdAddr            <= rdAddr;
            wbRdWriteEn         <= rdWriteEn & ~memWrite & ~misaligned;
            wbDestinationSelect <= destinationSelect;
            wbPc                <= pc;
            wbRdWriteData       <= (memRead & ~misaligned) ? load_data : memAddr;
            wbMisaligned        <= misaligned;
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: driver tasks push expected MEM/WB records,
// a monitor pops and compares whenever wbValid is seen.
module tb_mem_stage_lsu;

    logic        clk;
    logic        arst;
    logic        memValid;
    logic        memRead;
    logic        memWrite;
    logic [2:0]  memFunct3;
    logic [31:0] memAddr;
    logic [31:0] memStoreData;
    logic [4:0]  rdAddr;
    logic        rdWriteEn;
    logic [1:0]  destinationSelect;
    logic [31:0] pc;
    logic        stall;
    logic        dmemReqValid;
    logic        dmemReqReady;
    logic [31:0] dmemReqAddr;
    logic        dmemReqWe;
    logic [3:0]  dmemReqBe;
    logic [31:0] dmemReqWdata;
    logic        dmemRspValid;
    logic [31:0] dmemRspData;
    logic        wbValid;
    logic [4:0]  wbRdAddr;
    logic        wbRdWriteEn;
    logic [1:0]  wbDestinationSelect;
    logic [31:0] wbPc;
    logic [31:0] wbRdWriteData;
    logic        wbMisaligned;
    logic        fsm_state;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        we;
        logic [1:0]  dsel;
        logic [31:0] data;
        logic        mis;
        logic        chk_data;
    } wb_exp_t;

    wb_exp_t exp_q[$];
    int checks;
    int failures;

    mem_stage_lsu dut (
        .clk(clk), .arst(arst), .memValid(memValid), .memRead(memRead), .memWrite(memWrite),
        .memFunct3(memFunct3), .memAddr(memAddr), .memStoreData(memStoreData), .rdAddr(rdAddr),
        .rdWriteEn(rdWriteEn), .destinationSelect(destinationSelect), .pc(pc), .stall(stall),
        .dmemReqValid(dmemReqValid), .dmemReqReady(dmemReqReady), .dmemReqAddr(dmemReqAddr),
        .dmemReqWe(dmemReqWe), .dmemReqBe(dmemReqBe), .dmemReqWdata(dmemReqWdata),
        .dmemRspValid(dmemRspValid), .dmemRspData(dmemRspData), .wbValid(wbValid),
        .wbRdAddr(wbRdAddr), .wbRdWriteEn(wbRdWriteEn), .wbDestinationSelect(wbDestinationSelect),
        .wbPc(wbPc), .wbRdWriteData(wbRdWriteData), .wbMisaligned(wbMisaligned),
        .fsm_state(fsm_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic monitor();
        wb_exp_t e;
        forever begin
            @(negedge clk);
            if (!arst && wbValid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL wb_unexpected pc actual=%h expected=none", wbPc);
                end else begin
                    e = exp_q.pop_front();
                    check("wb_pc", wbPc, e.pc);
                    check("wb_rd", 32'(wbRdAddr), 32'(e.rd));
                    check("wb_we", 32'(wbRdWriteEn), 32'(e.we));
                    check("wb_dsel", 32'(wbDestinationSelect), 32'(e.dsel));
                    check("wb_mis", 32'(wbMisaligned), 32'(e.mis));
                    if (e.chk_data) check("wb_data", wbRdWriteData, e.data);
                end
            end
        end
    endtask

    // Entered and left at one time unit after a rising edge.
    task automatic run_op(input string name, input logic rd_op, input logic wr_op,
                          input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [4:0] rd, input logic we, input logic [1:0] dsel,
                          input logic [31:0] pc_v, input int ready_at, input int rsp_at,
                          input int n_cycles, input logic [31:0] rsp_word, input logic req_on,
                          input logic [3:0] req_be, input logic [31:0] req_wdata,
                          input int exp_stall, input logic [31:0] exp_data,
                          input logic exp_we, input logic exp_mis, input logic chk_data);
        int stall_cnt;
        exp_q.push_back('{pc: pc_v, rd: rd, we: exp_we, dsel: dsel, data: exp_data,
                          mis: exp_mis, chk_data: chk_data});
        stall_cnt = 0;
        for (int c = 0; c < n_cycles; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
            end
            memValid = 1'b1; memRead = rd_op; memWrite = wr_op; memFunct3 = f3;
            memAddr = addr; memStoreData = sdata; rdAddr = rd; rdWriteEn = we;
            destinationSelect = dsel; pc = pc_v;
            dmemReqReady = (c == ready_at);
            dmemRspValid = (c == rsp_at);
            dmemRspData  = rsp_word;
            @(negedge clk);
            if (stall) stall_cnt++;
            if (req_on && c <= ready_at) begin
                check({name, "_req_valid"}, 32'(dmemReqValid), 32'd1);
                check({name, "_req_addr"}, dmemReqAddr, addr & 32'hFFFF_FFFC);
                check({name, "_req_we"}, 32'(dmemReqWe), 32'(wr_op));
                check({name, "_req_be"}, 32'(dmemReqBe), 32'(req_be));
                if (wr_op) check({name, "_req_wdata"}, dmemReqWdata, req_wdata);
            end else begin
                check({name, "_no_req"}, 32'(dmemReqValid), 32'd0);
            end
        end
        check({name, "_stall_cycles"}, 32'(stall_cnt), 32'(exp_stall));
        @(posedge clk);
        #1;
        memValid = 1'b0; dmemReqReady = 1'b0; dmemRspValid = 1'b0;
    endtask

    // Idle slots; optionally pulses ready/response, which must both be ignored.
    task automatic idle(input int n, input logic pulse);
        for (int c = 0; c < n; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
            end
            memValid = 1'b0;
            dmemReqReady = pulse;
            dmemRspValid = pulse;
            dmemRspData = 32'h5A5A_5A5A;
            @(negedge clk);
            check("idle_no_req", 32'(dmemReqValid), 32'd0);
            check("idle_no_stall", 32'(stall), 32'd0);
        end
        @(posedge clk);
        #1;
        dmemReqReady = 1'b0; dmemRspValid = 1'b0;
    endtask

    initial begin
        checks = 0; failures = 0;
        arst = 1'b1; memValid = 1'b0; memRead = 1'b0; memWrite = 1'b0; memFunct3 = 3'b000;
        memAddr = 32'd0; memStoreData = 32'd0; rdAddr = 5'd0; rdWriteEn = 1'b0;
        destinationSelect = 2'd0; pc = 32'd0; dmemReqReady = 1'b0; dmemRspValid = 1'b0;
        dmemRspData = 32'd0;
        fork
            monitor();
        join_none

        #12;
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_req_valid", 32'(dmemReqValid), 32'd0);
        check("rst_state", 32'(fsm_state), 32'd0);
        check("rst_wb_valid", 32'(wbValid), 32'd0);
        check("rst_wb_we", 32'(wbRdWriteEn), 32'd0);
        check("rst_wb_dsel", 32'(wbDestinationSelect), 32'd0);
        check("rst_wb_data", wbRdWriteData, 32'd0);
        check("rst_wb_pc", wbPc, 32'd0);
        check("rst_wb_mis", 32'(wbMisaligned), 32'd0);
        @(posedge clk);
        #1;
        arst = 1'b0;

        //     name    rd wr  f3      addr          sdata         rd   we    dsel   pc            rdy rsp n  rsp_word      req be       wdata         stl data          we   mis  chk
        run_op("alu",  0, 0, 3'b000, 32'h0000_1234, 32'h0,        5'd5, 1'b1, 2'd0, 32'h0000_1000, -1, -1, 1, 32'h0,        0, 4'b0000, 32'h0,        0, 32'h0000_1234, 1'b1, 1'b0, 1'b1);
        run_op("lb",   1, 0, 3'b000, 32'h0000_0103, 32'h0,        5'd6, 1'b1, 2'd1, 32'h0000_1004,  0,  4, 5, 32'h80FF_0000, 1, 4'b1111, 32'h0,        4, 32'hFFFF_FF80, 1'b1, 1'b0, 1'b1);
        run_op("lbu",  1, 0, 3'b100, 32'h0000_0103, 32'h0,        5'd7, 1'b1, 2'd1, 32'h0000_1008,  0,  4, 5, 32'h80FF_0000, 1, 4'b1111, 32'h0,        4, 32'h0000_0080, 1'b1, 1'b0, 1'b1);
        run_op("sh",   0, 1, 3'b001, 32'h0000_0202, 32'hABCD_1234, 5'd8, 1'b1, 2'd0, 32'h0000_100C,  2, -1, 3, 32'h0,        1, 4'b1100, 32'h1234_1234, 2, 32'h0000_0202, 1'b0, 1'b0, 1'b1);
        run_op("lw_mis", 1, 0, 3'b010, 32'h0000_0301, 32'h0,      5'd9, 1'b1, 2'd1, 32'h0000_1010, -1, -1, 1, 32'h0,        0, 4'b0000, 32'h0,        0, 32'h0,         1'b0, 1'b1, 1'b0);
        run_op("lh",   1, 0, 3'b001, 32'h0000_0102, 32'h0,        5'd10, 1'b1, 2'd1, 32'h0000_1014, 1,  2, 3, 32'h8001_7F00, 1, 4'b1111, 32'h0,        2, 32'hFFFF_8001, 1'b1, 1'b0, 1'b1);
        run_op("lhu",  1, 0, 3'b101, 32'h0000_0100, 32'h0,        5'd11, 1'b1, 2'd1, 32'h0000_1018, 0,  1, 2, 32'h1234_F00D, 1, 4'b1111, 32'h0,        1, 32'h0000_F00D, 1'b1, 1'b0, 1'b1);
        run_op("lw",   1, 0, 3'b010, 32'h0000_0300, 32'h0,        5'd12, 1'b1, 2'd1, 32'h0000_101C, 0,  2, 3, 32'hDEAD_BEEF, 1, 4'b1111, 32'h0,        2, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1);
        run_op("sb",   0, 1, 3'b000, 32'h0000_0001, 32'h0000_00A5, 5'd13, 1'b1, 2'd0, 32'h0000_1020, 0, -1, 1, 32'h0,        1, 4'b0010, 32'hA5A5_A5A5, 0, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
        run_op("sw",   0, 1, 3'b010, 32'h0000_0040, 32'hCAFE_F00D, 5'd0, 1'b0, 2'd0, 32'h0000_1024,  1, -1, 2, 32'h0,        1, 4'b1111, 32'hCAFE_F00D, 1, 32'h0000_0040, 1'b0, 1'b0, 1'b1);
        run_op("alu_x0", 0, 0, 3'b000, 32'h0000_0055, 32'h0,      5'd0, 1'b1, 2'd2, 32'h0000_1028, -1, -1, 1, 32'h0,        0, 4'b0000, 32'h0,        0, 32'h0000_0055, 1'b1, 1'b0, 1'b1);
        run_op("sh_mis", 0, 1, 3'b001, 32'h0000_0203, 32'h1111_2222, 5'd14, 1'b0, 2'd0, 32'h0000_102C, -1, -1, 1, 32'h0,    0, 4'b0000, 32'h0,        0, 32'h0,         1'b0, 1'b1, 1'b0);
        idle(3, 1'b1);

        // Abandon a load in WAIT with an asynchronous reset.
        memValid = 1'b1; memRead = 1'b1; memWrite = 1'b0; memFunct3 = 3'b010;
        memAddr = 32'h0000_0400; rdAddr = 5'd7; rdWriteEn = 1'b1; destinationSelect = 2'd1;
        pc = 32'h0000_2000; dmemReqReady = 1'b1;
        @(negedge clk);
        check("abort_req_valid", 32'(dmemReqValid), 32'd1);
        @(posedge clk);
        #1;
        dmemReqReady = 1'b0;
        @(negedge clk);
        check("abort_wait_stall", 32'(stall), 32'd1);
        check("abort_wait_state", 32'(fsm_state), 32'd1);
        #2;
        arst = 1'b1;
        #1;
        check("abort_stall", 32'(stall), 32'd0);
        check("abort_req_valid_low", 32'(dmemReqValid), 32'd0);
        check("abort_state", 32'(fsm_state), 32'd0);
        check("abort_wb_valid", 32'(wbValid), 32'd0);
        check("abort_wb_rd", 32'(wbRdAddr), 32'd0);
        check("abort_wb_we", 32'(wbRdWriteEn), 32'd0);
        check("abort_wb_dsel", 32'(wbDestinationSelect), 32'd0);
        check("abort_wb_pc", wbPc, 32'd0);
        check("abort_wb_data", wbRdWriteData, 32'd0);
        check("abort_wb_mis", 32'(wbMisaligned), 32'd0);
        memValid = 1'b0;
        @(posedge clk);
        #1;
        arst = 1'b0;
        idle(2, 1'b0);
        dmemRspValid = 1'b1;
        dmemRspData = 32'h1357_9BDF;
        @(posedge clk);
        #1;
        dmemRspValid = 1'b0;
        @(negedge clk);
        check("late_rsp_wb_valid", 32'(wbValid), 32'd0);
        check("late_rsp_state", 32'(fsm_state), 32'd0);
        @(posedge clk);
        #1;
        idle(2, 1'b0);

        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
